// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with req/ack data-memory handshake and load formatting.
// Define MEM_TIMEOUT_EN to abort accesses that see no dm_ack within TIMEOUT_CYCLES.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_lw,
  input  logic              ex_sw,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              ex_lwsrc,
  input  logic [31:0]       ex_movsrc_result,
  output logic              mem_lwsrc,
  output logic [31:0]       mem_movsrc_result,
  output logic [31:0]       mem_DM_out,
  output logic              mem_stall,
  output logic              mem_misalign,
  output logic              mem_bus_err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state, state_nx;
  logic        access, misaligned, start, done, tmo;
  logic [1:0]  l_size, l_off;
  logic        l_uns;
  logic [3:0]  be_nx;
  logic [31:0] wd_nx, fmt;
  logic [15:0] lane;
  assign mem_lwsrc         = ex_lwsrc;
  assign mem_movsrc_result = ex_movsrc_result;
  always_comb begin
    access     = ex_valid & (ex_lw | ex_sw);
    misaligned = ex_size[1] ? |ex_addr[1:0] : ex_size[0] & ex_addr[0];
    start      = state == IDLE & access & !misaligned;
    done       = state == WAIT & (dm_ack | tmo);
    state_nx   = start ? WAIT : done ? IDLE : state;
    be_nx      = ex_size[1] ? 4'b1111 : ex_size[0] ? (ex_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ex_addr[1:0];
    wd_nx      = ex_size[1] ? ex_wdata : ex_size[0] ? {2{ex_wdata[15:0]}} : {4{ex_wdata[7:0]}};
    lane       = 16'(dm_rdata >> {l_off, 3'b000});
    fmt        = l_size == 2'd0 ? {{24{!l_uns & lane[7]}}, lane[7:0]} :
                 l_size == 2'd1 ? {{16{!l_uns & lane[15]}}, lane} : dm_rdata;
  end
  // Outputs are gated by rst so that an access presented during reset is invisible.
  always_comb begin
    mem_stall    = rst & (start | (state == WAIT & !done));
    mem_DM_out   = (rst & state == WAIT & dm_ack & !dm_we) ? fmt : 32'd0;
    mem_misalign = rst & state == IDLE & access & misaligned;
    mem_bus_err  = rst & state == WAIT & tmo;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= 4'd0;
      dm_wdata <= 32'd0;
      l_size   <= 2'd0;
      l_uns    <= 1'b0;
      l_off    <= 2'd0;
    end else begin
      state  <= state_nx;
      dm_req <= state_nx == WAIT;
      if (start) begin
        dm_we    <= ex_sw;
        dm_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
        dm_be    <= be_nx;
        dm_wdata <= wd_nx;
        l_size   <= ex_size;
        l_uns    <= ex_unsigned;
        l_off    <= ex_addr[1:0];
      end
    end
  end
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // An ack on the final cycle still completes normally.
  assign tmo = !dm_ack & cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= start ? '0 : (state == WAIT & !dm_ack) ? cnt + CW'(1) : cnt;
  end
`else
  logic unused_timeout;
  assign tmo            = 1'b0;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table, corner sequences and randomized model check for mem_access_unit.
module tb_mem_access_unit;
  logic        clk = 1'b0, rst = 1'b0;
  logic        ex_valid, ex_lw, ex_sw, ex_unsigned, ex_lwsrc, dm_ack;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata, ex_movsrc_result, dm_rdata;
  logic        mem_lwsrc, mem_stall, mem_misalign, mem_bus_err, dm_req, dm_we;
  logic [31:0] mem_movsrc_result, mem_DM_out, dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  int n_cmp = 0, n_err = 0;
  localparam int TO = 16;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_lw(ex_lw), .ex_sw(ex_sw), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_lwsrc(ex_lwsrc),
    .ex_movsrc_result(ex_movsrc_result), .mem_lwsrc(mem_lwsrc), .mem_movsrc_result(mem_movsrc_result),
    .mem_DM_out(mem_DM_out), .mem_stall(mem_stall), .mem_misalign(mem_misalign), .mem_bus_err(mem_bus_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        lw, sw;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    int          waits;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wd, out;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_lw = 1'b0; ex_sw = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
    ex_addr = 32'd0; ex_wdata = 32'd0; dm_ack = 1'b0;
  endtask

  task automatic set_op(input logic lw, input logic sw, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    ex_valid = 1'b1; ex_lw = lw; ex_sw = sw; ex_size = size; ex_unsigned = uns;
    ex_addr = addr; ex_wdata = wdata; dm_ack = 1'b0;
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic is_mis(input logic [1:0] s, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] s, input logic [31:0] a);
    return 4'(((1 << nbytes(s)) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] s, input logic [31:0] w);
    int n = nbytes(s);
    return n == 1 ? {24'd0, w[7:0]} * 32'h01010101 : n == 2 ? {16'd0, w[15:0]} * 32'h00010001 : w;
  endfunction

  function automatic logic [31:0] exp_fmt(input logic [31:0] rd, input logic [1:0] s, input logic uns, input int off);
    int n = nbytes(s);
    logic [63:0] mask, v;
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = ({32'd0, rd} >> (8 * off)) & mask;
    if (!uns && v[8 * n - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic run_vec(input vec_t v);
    set_op(v.lw, v.sw, v.size, v.uns, v.addr, v.wdata);
    @(negedge clk);
    chk1("vec_misalign", mem_misalign, v.mis);
    chk1("vec_stall_accept", mem_stall, !v.mis);
    chk("vec_out_accept", mem_DM_out, 32'd0);
    chk1("vec_req_accept", dm_req, 1'b0);
    if (!v.mis)
      for (int w = 0; w <= v.waits; w++) begin
        tick();
        dm_ack = w == v.waits;
        dm_rdata = dm_ack ? v.rdata : $urandom;
        @(negedge clk);
        chk1("vec_req", dm_req, 1'b1);
        chk1("vec_we", dm_we, v.sw);
        chk("vec_addr", dm_addr, v.addr & ~32'h3);
        chk("vec_be", 32'(dm_be), 32'(v.be));
        chk("vec_wdata", dm_wdata, v.wd);
        chk1("vec_stall_wait", mem_stall, w != v.waits);
        chk("vec_out", mem_DM_out, w == v.waits ? v.out : 32'd0);
      end
    tick();
    idle();
    @(negedge clk);
    chk1("vec_req_after", dm_req, 1'b0);
    chk1("vec_stall_after", mem_stall, 1'b0);
    tick();
  endtask

  logic        busy, prev_stall, p_we, p_uns, acc, e_stall, e_mis, e_err;
  logic [1:0]  p_size;
  logic [3:0]  p_be;
  logic [31:0] p_addr, p_wd, e_out;
  int          p_off, waitn;

  initial begin
    idle();
    ex_lwsrc = 1'b0; ex_movsrc_result = 32'd0; dm_rdata = 32'd0;
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h41, 32'h0);
    #3;
    chk1("rst_misalign", mem_misalign, 1'b0);
    chk1("rst_stall_mis", mem_stall, 1'b0);
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    dm_ack = 1'b1; dm_rdata = 32'h12345678;
    #4;
    chk1("rst_stall", mem_stall, 1'b0);
    chk("rst_out", mem_DM_out, 32'd0);
    chk1("rst_bus_err", mem_bus_err, 1'b0);
    chk1("rst_req", dm_req, 1'b0);
    chk1("rst_we", dm_we, 1'b0);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_be", 32'(dm_be), 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    idle();
    #1 rst = 1'b1;
    tick();

    vt[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h000000AA, 32'h80FFFFFF, 3, 1'b0, 4'b1000, 32'hAAAAAAAA, 32'hFFFFFF80};
    vt[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h000000AA, 32'h80FFFFFF, 0, 1'b0, 4'b1000, 32'hAAAAAAAA, 32'h00000080};
    vt[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h022, 32'h1234ABCD, 32'hFFFFFFFF, 1, 1'b0, 4'b1100, 32'hABCDABCD, 32'h00000000};
    vt[3]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h041, 32'h00000000, 32'h00000000, 0, 1'b1, 4'b0000, 32'h00000000, 32'h00000000};
    vt[4]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h013, 32'h00000000, 32'h00000000, 0, 1'b1, 4'b0000, 32'h00000000, 32'h00000000};
    vt[5]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h012, 32'h0000BEEF, 32'h80011234, 2, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'hFFFF8001};
    vt[6]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h010, 32'h0000BEEF, 32'h8001F00D, 0, 1'b0, 4'b0011, 32'hBEEFBEEF, 32'h0000F00D};
    vt[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h001, 32'hFFFFFF5A, 32'h00000000, 0, 1'b0, 4'b0010, 32'h5A5A5A5A, 32'h00000000};
    vt[8]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h044, 32'h01234567, 32'hDEADBEEF, 1, 1'b0, 4'b1111, 32'h01234567, 32'hDEADBEEF};
    vt[9]  = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h048, 32'hCAFEF00D, 32'h13579BDF, 0, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h13579BDF};
    vt[10] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h04A, 32'h00000000, 32'h00000000, 0, 1'b1, 4'b0000, 32'h00000000, 32'h00000000};
    vt[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h102, 32'h00000000, 32'h007F0000, 0, 1'b0, 4'b0100, 32'h00000000, 32'h0000007F};
    vt[12] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h04C, 32'h89ABCDEF, 32'h00000000, 2, 1'b0, 4'b1111, 32'h89ABCDEF, 32'h00000000};
    vt[13] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h005, 32'h00000000, 32'h00009C00, 0, 1'b0, 4'b0010, 32'h00000000, 32'hFFFFFF9C};
    for (int i = 0; i < 14; i++) run_vec(vt[i]);

    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk1("b2b_stall1", mem_stall, 1'b1);
    chk1("b2b_req1_off", dm_req, 1'b0);
    tick();
    dm_ack = 1'b1; dm_rdata = 32'h11112222;
    @(negedge clk);
    chk1("b2b_req2", dm_req, 1'b1);
    chk1("b2b_stall2", mem_stall, 1'b0);
    chk("b2b_out2", mem_DM_out, 32'h11112222);
    tick();
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    chk1("b2b_req3_off", dm_req, 1'b0);
    chk1("b2b_stall3", mem_stall, 1'b1);
    tick();
    dm_ack = 1'b1; dm_rdata = 32'h33334444;
    @(negedge clk);
    chk1("b2b_req4", dm_req, 1'b1);
    chk("b2b_addr4", dm_addr, 32'h14);
    chk("b2b_out4", mem_DM_out, 32'h33334444);
    tick();
    idle();
    ex_valid = 1'b1; ex_lwsrc = 1'b1; ex_movsrc_result = 32'h5555AAAA;
    @(negedge clk);
    chk1("nomem_stall", mem_stall, 1'b0);
    chk1("nomem_req", dm_req, 1'b0);
    chk1("nomem_lwsrc", mem_lwsrc, 1'b1);
    chk("nomem_movsrc", mem_movsrc_result, 32'h5555AAAA);
    tick();

    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    tick();
    @(negedge clk);
    chk1("rstw_req_before", dm_req, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk1("rstw_req_drop", dm_req, 1'b0);
    chk1("rstw_stall", mem_stall, 1'b0);
    idle();
    tick();
    rst = 1'b1;
    tick();
    tick();
    dm_ack = 1'b1; dm_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk1("late_ack_req", dm_req, 1'b0);
    chk("late_ack_out", mem_DM_out, 32'd0);
    chk1("late_ack_stall", mem_stall, 1'b0);
    tick();
    dm_ack = 1'b0;
    @(negedge clk);
    chk1("late_ack_idle", dm_req, 1'b0);
    tick();

`ifdef MEM_TIMEOUT_EN
    for (int k = 0; k < 2; k++) begin
      set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
      @(negedge clk);
      chk1("to_accept", mem_stall, 1'b1);
      for (int w = 1; w <= TO; w++) begin
        tick();
        dm_ack = k == 1 && w == TO; dm_rdata = 32'hA5A55A5A;
        @(negedge clk);
        chk1("to_bus_err", mem_bus_err, k == 0 && w == TO);
        chk1("to_stall", mem_stall, w != TO);
        chk1("to_req", dm_req, 1'b1);
        chk("to_out", mem_DM_out, k == 1 && w == TO ? 32'hA5A55A5A : 32'd0);
      end
      tick();
      idle();
      @(negedge clk);
      chk1("to_req_fall", dm_req, 1'b0);
      chk1("to_err_once", mem_bus_err, 1'b0);
      tick();
    end
`else
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    for (int w = 1; w <= 21; w++) begin
      tick();
      dm_ack = w == 21; dm_rdata = 32'hA5A55A5A;
      @(negedge clk);
      chk1("nto_bus_err", mem_bus_err, 1'b0);
      chk1("nto_stall", mem_stall, w != 21);
      chk1("nto_req", dm_req, 1'b1);
    end
    chk("nto_out", mem_DM_out, 32'hA5A55A5A);
    tick();
    idle();
    tick();
`endif

    busy = 1'b0; prev_stall = 1'b0; waitn = 0;
    p_we = 1'b0; p_uns = 1'b0; p_size = 2'd0; p_be = 4'd0; p_addr = 32'd0; p_wd = 32'd0; p_off = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!prev_stall) begin
        int op;
        op = int'($urandom % 3);
        ex_valid = ($urandom % 8) != 0;
        ex_lw = op == 0; ex_sw = op == 1;
        ex_size = 2'($urandom % 4); ex_unsigned = 1'($urandom % 2);
        ex_addr = $urandom; ex_wdata = $urandom;
        ex_lwsrc = 1'($urandom % 2); ex_movsrc_result = $urandom;
      end
      dm_ack = busy ? ($urandom % 3) == 0 : ($urandom % 8) == 0;
      dm_rdata = $urandom;
      @(negedge clk);
      acc = ex_valid & (ex_lw | ex_sw);
      e_stall = 1'b0; e_mis = 1'b0; e_err = 1'b0; e_out = 32'd0;
      if (!busy) begin
        e_mis = acc && is_mis(ex_size, ex_addr);
        e_stall = acc && !e_mis;
      end else if (dm_ack) e_out = p_we ? 32'd0 : exp_fmt(dm_rdata, p_size, p_uns, p_off);
      else if (TMO_EN && waitn == TO - 1) e_err = 1'b1;
      else e_stall = 1'b1;
      chk1("rnd_req", dm_req, busy);
      if (busy) begin
        chk1("rnd_we", dm_we, p_we);
        chk("rnd_addr", dm_addr, p_addr);
        chk("rnd_be", 32'(dm_be), 32'(p_be));
        chk("rnd_wdata", dm_wdata, p_wd);
      end
      chk1("rnd_stall", mem_stall, e_stall);
      chk1("rnd_misalign", mem_misalign, e_mis);
      chk1("rnd_bus_err", mem_bus_err, e_err);
      chk("rnd_out", mem_DM_out, e_out);
      chk1("rnd_lwsrc", mem_lwsrc, ex_lwsrc);
      chk("rnd_movsrc", mem_movsrc_result, ex_movsrc_result);
      if (!busy) begin
        if (e_stall) begin
          busy = 1'b1; waitn = 0;
          p_we = ex_sw; p_uns = ex_unsigned; p_size = ex_size; p_off = int'(ex_addr[1:0]);
          p_addr = ex_addr & ~32'h3; p_be = exp_be(ex_size, ex_addr); p_wd = exp_wd(ex_size, ex_wdata);
        end
      end else if (dm_ack || e_err) busy = 1'b0;
      else waitn++;
      prev_stall = e_stall;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
